inst_encode_loader: RTL and testbench

//  Inverse of the immediate extender. Takes instruction fields plus a signed 32-bit immediate.

---
 rtl/inst_encode_loader.sv | 169 ++++++++++++++++
 tb/tb_inst_encode_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs RV32I instruction fields plus a signed immediate
// into a 32-bit word, range-checks the immediate for the opcode's format,
// and writes accepted words to IMEM at a self-incrementing word address.
// Pipeline is IDLE -> ENC -> WR, one word per three cycles.
module inst_encode_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W:0]   wr_cnt
);

    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_BASE  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_t;

    state_t             r_state, w_next;
    logic [6:0]         r_op;
    logic [4:0]         r_rd, r_rs1, r_rs2;
    logic [2:0]         r_f3;
    logic [6:0]         r_f7;
    logic [31:0]        r_imm;
    logic               r_ok;
    logic [31:0]        r_wdata;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W:0]    r_wr_cnt;
    logic               r_err;
    logic [7:0]         r_err_cnt;

    logic               w_full, w_accept, w_ok;
    logic [31:0]        w_word;
    logic               w_rng_i, w_rng_b, w_rng_j;

    // Immediate fits the format when all bits above its sign bit equal the sign bit.
    assign w_rng_i  = (&r_imm[31:11]) | ~(|r_imm[31:11]);
    assign w_rng_b  = (&r_imm[31:12]) | ~(|r_imm[31:12]);
    assign w_rng_j  = (&r_imm[31:20]) | ~(|r_imm[31:20]);
    assign w_full   = (r_wr_cnt == L_DEPTH);
    assign w_accept = in_valid & in_ready;

    // State register; rst and clear both abort any in-flight word.
    always_ff @(posedge clk) begin
        if (rst || clear) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    // Next state: fixed three-cycle walk once a field set is accepted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ENC;
            S_ENC:   w_next = S_WR;
            S_WR:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: write strobe only in WR with a good word, suppressed by rst/clear.
    always_comb begin
        in_ready = (r_state == S_IDLE) && !w_full && !clear;
        im_we    = (r_state == S_WR) && r_ok && !rst && !clear;
    end

    // Encoder over the latched fields; unknown formats fall through as rejects.
    always_comb begin
        w_word = '0;
        w_ok   = 1'b0;
        if (r_op[1:0] == 2'b11) begin
            case (r_op[6:2])
                5'b01101, 5'b00101: begin
                    w_word = {r_imm[31:12], r_rd, r_op};
                    w_ok   = (r_imm[11:0] == 12'd0);
                end
                5'b11011: begin
                    w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op};
                    w_ok   = w_rng_j && !r_imm[0];
                end
                5'b11001, 5'b00000, 5'b00100: begin
                    w_word = {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
                    w_ok   = w_rng_i;
                end
                5'b01000: begin
                    w_word = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op};
                    w_ok   = w_rng_i;
                end
                5'b11000: begin
                    w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3,
                              r_imm[4:1], r_imm[11], r_op};
                    w_ok   = w_rng_b && !r_imm[0];
                end
                5'b01100: begin
                    w_word = {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op};
                    w_ok   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath: latch fields on accept, encode in ENC, commit or flag error in WR.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_f3      <= '0;
            r_f7      <= '0;
            r_imm     <= '0;
            r_ok      <= 1'b0;
            r_wdata   <= '0;
            r_addr    <= L_BASE;
            r_wr_cnt  <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= in_opcode;
                r_rd  <= in_rd;
                r_rs1 <= in_rs1;
                r_rs2 <= in_rs2;
                r_f3  <= in_funct3;
                r_f7  <= in_funct7;
                r_imm <= in_imm;
            end
            if (r_state == S_ENC) begin
                r_ok <= w_ok;
                // Rejected words leave the previous data on the bus.
                if (w_ok) r_wdata <= w_word;
            end
            if (r_state == S_WR) begin
                if (r_ok) begin
                    r_addr   <= r_addr + 1'b1;
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end else begin
                    r_err <= 1'b1;
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign full     = w_full;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Bench for inst_encode_loader: random and directed field sets, expected
// IMEM writes queued by a reference encoder, checked by a separate monitor.
module tb_inst_encode_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int BASE   = 5;

    logic              clk = 1'b0;
    logic              rst, clear, in_valid, in_ready;
    logic [6:0]        in_opcode, in_funct7;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic [31:0]       in_imm;
    logic              im_we, full, err;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [7:0]        err_cnt;
    logic [ADDR_W:0]   wr_cnt;

    inst_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .full(full),
        .err(err), .err_cnt(err_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       w;
        logic [31:0]       c;
    } exp_t;

    exp_t        q[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    logic [31:0] cyc    = 0;

    // Reference model state
    int          m_addr, m_wr, m_errcnt;
    logic        m_err;
    logic [31:0] m_lastw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with nothing expected", im_addr, im_wdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr",  32'(im_addr), 32'(e.a));
                chk("wr_data",  im_wdata, e.w);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    // Reference encoder written from the format rules with arithmetic.
    function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm, output logic ok, output logic [31:0] w);
        int s;
        logic [31:0] rdp, rs1p, rs2p, f3p;
        s    = $signed(imm);
        rdp  = 32'(rd) << 7;
        rs1p = 32'(rs1) << 15;
        rs2p = 32'(rs2) << 20;
        f3p  = 32'(f3) << 12;
        ok   = 1'b0;
        w    = 32'd0;
        case (op)
            7'b0110111, 7'b0010111: begin
                ok = (imm % 4096) == 0;
                w  = (imm & 32'hFFFFF000) | rdp | 32'(op);
            end
            7'b1101111: begin
                ok = s >= -1048576 && s <= 1048575 && (imm % 2) == 0;
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                     (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdp | 32'(op);
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                ok = s >= -2048 && s <= 2047;
                w  = ((imm & 32'hFFF) << 20) | rs1p | f3p | rdp | 32'(op);
            end
            7'b0100011: begin
                ok = s >= -2048 && s <= 2047;
                w  = (((imm >> 5) & 32'h7F) << 25) | rs2p | rs1p | f3p | ((imm & 32'h1F) << 7) | 32'(op);
            end
            7'b1100011: begin
                ok = s >= -4096 && s <= 4095 && (imm % 2) == 0;
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | rs2p | rs1p | f3p |
                     (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'(op);
            end
            7'b0110011: begin
                ok = 1'b1;
                w  = (32'(f7) << 25) | rs2p | rs1p | f3p | rdp | 32'(op);
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_addr = BASE; m_wr = 0; m_err = 1'b0; m_errcnt = 0; m_lastw = 32'd0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_addr"},   32'(im_addr), 32'(m_addr));
        chk({tag, "_wrcnt"},  32'(wr_cnt), 32'(m_wr));
        chk({tag, "_err"},    32'(err), 32'(m_err));
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'(m_errcnt));
        chk({tag, "_full"},   32'(full), 32'(m_wr == DEPTH));
        chk({tag, "_wdata"},  im_wdata, m_lastw);
        chk({tag, "_ready"},  32'(in_ready), 32'(m_wr != DEPTH));
    endtask

    task automatic scramble();
        in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
        in_imm = $urandom;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after WR with status checked.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input bit kat, input logic [31:0] kat_w, input string tag);
        int t;
        logic ok;
        logic [31:0] w;
        exp_t e;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_tot++;
            $display("FAIL %s_ready_timeout: in_ready stayed %b, expected 1", tag, in_ready);
            return;
        end
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        ref_enc(op, rd, rs1, rs2, f3, f7, imm, ok, w);
        if (kat) begin
            ok = 1'b1;
            w  = kat_w;
        end
        if (ok) begin
            e.a = ADDR_W'(m_addr); e.w = w; e.c = cyc + 2;
            q.push_back(e);
            m_addr  = (m_addr + 1) % (1 << ADDR_W);
            m_wr++;
            m_lastw = w;
        end else begin
            m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        @(negedge clk);
        scramble();
        @(negedge clk);
        chk_status(tag);
    endtask

    // Accept a word, then hit rst or clear during its WR cycle.
    task automatic abort(input bit use_rst, input string tag);
        in_opcode = 7'b0110011; in_rd = 5'd3; in_rs1 = 5'd4; in_rs2 = 5'd5;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1; else clear = 1'b1;
        @(negedge clk);
        chk({tag, "_we_in_wr"}, 32'(im_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0;
        @(negedge clk);
        model_reset();
        chk({tag, "_we_after"}, 32'(im_we), 32'd0);
        chk_status(tag);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic rand_fields(output logic [6:0] op, output logic [31:0] imm);
        logic [6:0] ops[9];
        logic [31:0] bnd[12];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                7'b0010011, 7'b0100011, 7'b1100011, 7'b0110011};
        bnd = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4095,
                32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'hFFEFFFFE};
        if ($urandom_range(0, 4) == 0) op = 7'($urandom);
        else op = ops[$urandom_range(0, 8)];
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
            2: imm = bnd[$urandom_range(0, 11)];
            default: imm = $urandom & 32'hFFFFF000;
        endcase
    endtask

    initial begin
        logic [6:0] op;
        logic [31:0] imm;
        logic ok;
        logic [31:0] w;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(im_we), 32'd0);
        chk_status("rst");
        rst = 1'b0;
        @(negedge clk);

        // Known-answer words
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093, "addi");
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7, "lui");
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        1'b1, 32'h008000EF, "jal");
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, "beq");

        // Range rejects, then a good word reuses the same address
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, "rej_i");
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,    1'b0, 32'd0, "rej_b");
        send(7'b0010010, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,    1'b0, 32'd0, "rej_op");
        send(7'b0110011, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'd0,   1'b0, 32'd0, "after_rej");

        abort(1'b1, "abort_rst");
        abort(1'b0, "abort_clr");

        // Fill to DEPTH (address wraps past 15), then confirm writes are blocked
        for (int i = 0; i < DEPTH; i++) begin
            do begin
                rand_fields(op, imm);
                ref_enc(op, 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 7'(i), imm, ok, w);
            end while (!ok);
            send(op, 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 7'(i), imm, 1'b0, 32'd0, "fill");
        end
        in_opcode = 7'b0110011; in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk_status("full_hold");
        do_clear();
        chk_status("post_clear");

        // Random field sets
        for (int i = 0; i < 60; i++) begin
            if (m_wr == DEPTH) do_clear();
            rand_fields(op, imm);
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 imm, 1'b0, 32'd0, "rand");
        end

        // Error counter saturation
        do_clear();
        for (int i = 0; i < 257; i++)
            send(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, "sat");

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
